// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage with PC, IF/ID register and one-entry skid (optional perf counters: IF_PERF_CNT_EN)
module if_fetch_stage #(
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Start_PC,
  input  logic        Stall_ID,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] PC_out,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PC4,
  output logic [31:0] IFID_Instr,
  output logic        IFID_Valid,
  output logic [31:0] Fetch_Count,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid_data;
  logic        req;

  logic        active;
  logic        take_redirect;
  logic        deliver_mem;
  logic        capture_skid;
  logic        deliver_skid;
  logic        bubble;
  logic [31:0] redirect_target;
  logic [31:0] pc_next_seq;

  assign Imem_Req  = req;
  assign Imem_Addr = pc;
  assign PC_out    = pc;

  // Decode this cycle's event; redirect outranks stall, which outranks normal flow
  always_comb begin
    active          = (state == ST_FETCH) || (state == ST_HOLD);
    take_redirect   = active && Redirect;
    deliver_mem     = (state == ST_FETCH) && !Redirect && Imem_Ready && !Stall_ID;
    capture_skid    = (state == ST_FETCH) && !Redirect && Imem_Ready && Stall_ID;
    deliver_skid    = (state == ST_HOLD) && !Redirect && !Stall_ID;
    bubble          = (state == ST_FETCH) && !Redirect && !Imem_Ready && !Stall_ID;
    redirect_target = Redirect_PC & ~32'h0000_0003;
    pc_next_seq     = pc + PC_STEP;
  end

  // Fetch FSM: owns PC, request, skid word and the IF/ID register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_BOOT;
      pc         <= 32'd0;
      req        <= 1'b0;
      skid_data  <= 32'd0;
      IFID_PC    <= 32'd0;
      IFID_PC4   <= 32'd0;
      IFID_Instr <= NOP_INSTR;
      IFID_Valid <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          pc    <= Start_PC;
          req   <= 1'b1;
          state <= ST_FETCH;
        end
        ST_FETCH, ST_HOLD: begin
          if (take_redirect) begin
            // Squash the IF/ID slot and any parked word; returning data is dropped
            pc         <= redirect_target;
            IFID_Valid <= 1'b0;
            IFID_Instr <= NOP_INSTR;
            skid_data  <= 32'd0;
            req        <= 1'b1;
            state      <= ST_FETCH;
          end else if (deliver_mem || deliver_skid) begin
            IFID_PC    <= pc;
            IFID_PC4   <= pc_next_seq;
            IFID_Instr <= deliver_skid ? skid_data : Imem_Rdata;
            IFID_Valid <= 1'b1;
            pc         <= pc_next_seq;
            req        <= 1'b1;
            state      <= ST_FETCH;
          end else if (capture_skid) begin
            // Decode is stalled: park the word and stop requesting until release
            skid_data <= Imem_Rdata;
            req       <= 1'b0;
            state     <= ST_HOLD;
          end else if (bubble) begin
            IFID_Valid <= 1'b0;
            IFID_Instr <= NOP_INSTR;
          end
        end
        default: begin
          state <= ST_BOOT;
          req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  assign Fetch_Count = fetch_cnt;
  assign Stall_Count = stall_cnt;
  assign Flush_Count = flush_cnt;

  // Wrapping performance counters for delivered instructions, stall cycles and redirects
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (deliver_mem || deliver_skid) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (active && Stall_ID) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (take_redirect) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`else
  assign Fetch_Count = 32'd0;
  assign Stall_Count = 32'd0;
  assign Flush_Count = 32'd0;
`endif

endmodule
